// File: rtl/anton_neopixel_rx.sv
// WS2812 line receiver: decodes high-pulse widths into bits, packs bytes
// MSB-first into a local buffer and closes the frame on a long low gap.
// The buffer and the status registers share one 14-bit byte bus.

`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 385
`endif

module anton_neopixel_rx #(
    parameter int BUFFER_END  = `BUFFER_END_DEFAULT,
    parameter int RESET_DELAY = `RESET_DELAY_DEFAULT,
    parameter int ONE_THRESH  = 4,
    parameter int HIGH_MAX    = 7
) (
    input  logic        clk7mhz,
    input  logic        resetn,
    input  logic        neoDataIn,
    output logic        rxState,
    output logic        frameDone,
    input  logic [13:0] busAddr,
    input  logic [7:0]  busDataIn,
    input  logic        busWrite,
    input  logic        busRead,
    output logic [7:0]  busDataOut
);

    localparam int          BUF_AW    = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1;
    localparam logic [12:0] BUF_LAST  = 13'(BUFFER_END);
    localparam logic [15:0] GAP_TICKS = 16'(RESET_DELAY);
    localparam logic [3:0]  ONE_TICKS = 4'(ONE_THRESH);
    localparam logic [3:0]  HI_LIMIT  = 4'(HIGH_MAX);

    typedef enum logic [1:0] {S_WAIT_GAP, S_IDLE, S_HIGH, S_LOW} state_t;

    state_t      state, state_n;
    logic        line_p0, line_p1, line_p2;
    logic        rise, fall;
    logic [15:0] lo_cnt;
    logic [3:0]  hi_cnt;
    logic [2:0]  bit_cnt;
    logic [12:0] idx;
    logic [12:0] count;
    logic [7:0]  shift_reg;
    logic [7:0]  buf_mem [0:BUFFER_END];
    logic        enable, frame_valid, overflow, error, partial;
    logic        start_frame, take_bit, bit_val, pulse_err, close_frame;
    logic        lo_load, lo_inc, lo_zero, hi_load, hi_inc;
    logic        byte_done, wr_en, clear_now, ctrl_wr;
    logic [7:0]  rd_data;
    logic        unused_bus;

    assign rise       = line_p1 & ~line_p2;
    assign fall       = ~line_p1 & line_p2;
    assign ctrl_wr    = busWrite && busAddr[13] && (busAddr[1:0] == 2'd2);
    assign clear_now  = ctrl_wr && busDataIn[1];
    assign byte_done  = take_bit && (bit_cnt == 3'd7);
    assign wr_en      = byte_done && (idx <= BUF_LAST);
    assign unused_bus = ^busDataIn[7:2];

    // Two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk7mhz or negedge resetn) begin
        if (!resetn) begin
            line_p0 <= 1'b0;
            line_p1 <= 1'b0;
            line_p2 <= 1'b0;
        end else begin
            line_p0 <= neoDataIn;
            line_p1 <= line_p0;
            line_p2 <= line_p1;
        end
    end

    // State register; rxState follows whether the next state is inside a frame
    always_ff @(posedge clk7mhz or negedge resetn) begin
        if (!resetn) begin
            state   <= S_WAIT_GAP;
            rxState <= 1'b0;
        end else begin
            state   <= state_n;
            rxState <= (state_n == S_HIGH) || (state_n == S_LOW);
        end
    end

    // Next-state decode and per-cycle strobes for the counters and byte packer
    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        take_bit    = 1'b0;
        bit_val     = 1'b0;
        pulse_err   = 1'b0;
        close_frame = 1'b0;
        lo_load     = 1'b0;
        lo_inc      = 1'b0;
        lo_zero     = 1'b0;
        hi_load     = 1'b0;
        hi_inc      = 1'b0;
        if (!enable || clear_now) begin
            state_n = S_WAIT_GAP;
            lo_zero = 1'b1;
        end else begin
            case (state)
                S_WAIT_GAP: begin
                    if (line_p1) begin
                        lo_zero = 1'b1;
                    end else if (lo_cnt + 16'd1 == GAP_TICKS) begin
                        state_n = S_IDLE;
                    end else begin
                        lo_inc = 1'b1;
                    end
                end
                S_IDLE: begin
                    if (rise) begin
                        state_n     = S_HIGH;
                        start_frame = 1'b1;
                        hi_load     = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        take_bit = 1'b1;
                        bit_val  = (hi_cnt >= ONE_TICKS);
                        lo_load  = 1'b1;
                        state_n  = S_LOW;
                    end else if (hi_cnt >= HI_LIMIT) begin
                        // Pulse too long to be WS2812 data: resync on the next gap
                        pulse_err = 1'b1;
                        lo_zero   = 1'b1;
                        state_n   = S_WAIT_GAP;
                    end else begin
                        hi_inc = 1'b1;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state_n = S_HIGH;
                        hi_load = 1'b1;
                    end else if (lo_cnt == GAP_TICKS) begin
                        close_frame = 1'b1;
                        state_n     = S_IDLE;
                    end else begin
                        lo_inc = 1'b1;
                    end
                end
                default: state_n = S_WAIT_GAP;
            endcase
        end
    end

    // Pulse-width counters, bit/byte position, latched count and sticky flags
    always_ff @(posedge clk7mhz or negedge resetn) begin
        if (!resetn) begin
            lo_cnt      <= '0;
            hi_cnt      <= '0;
            bit_cnt     <= '0;
            idx         <= '0;
            count       <= '0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
            error       <= 1'b0;
            partial     <= 1'b0;
            frameDone   <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            if (lo_zero)      lo_cnt <= '0;
            else if (lo_load) lo_cnt <= 16'd1;
            else if (lo_inc)  lo_cnt <= lo_cnt + 16'd1;
            if (hi_load)      hi_cnt <= 4'd1;
            else if (hi_inc)  hi_cnt <= hi_cnt + 4'd1;
            if (start_frame) begin
                idx     <= '0;
                bit_cnt <= '0;
            end else if (take_bit) begin
                bit_cnt <= bit_cnt + 3'd1;
                // Index stops one past the last slot so count saturates there
                if (byte_done && (idx <= BUF_LAST)) idx <= idx + 13'd1;
            end
            if (clear_now) begin
                count       <= '0;
                frame_valid <= 1'b0;
                overflow    <= 1'b0;
                error       <= 1'b0;
                partial     <= 1'b0;
            end else begin
                if (close_frame) begin
                    count       <= idx;
                    frame_valid <= 1'b1;
                    frameDone   <= 1'b1;
                    if (bit_cnt != 3'd0) partial <= 1'b1;
                end
                if (pulse_err) error <= 1'b1;
                if (byte_done && (idx > BUF_LAST)) overflow <= 1'b1;
            end
        end
    end

    // Bit shifter; contents only matter once eight bits have arrived
    always_ff @(posedge clk7mhz) begin
        if (take_bit) shift_reg <= {shift_reg[6:0], bit_val};
    end

    // Byte buffer write on the eighth bit of each byte
    always_ff @(posedge clk7mhz) begin
        if (wr_en) buf_mem[idx[BUF_AW-1:0]] <= {shift_reg[6:0], bit_val};
    end

    // Read multiplexer for buffer and register space
    always_comb begin
        rd_data = '0;
        if (busAddr[13]) begin
            case (busAddr[1:0])
                2'd0:    rd_data = count[7:0];
                2'd1:    rd_data = {3'b000, count[12:8]};
                2'd2:    rd_data = {2'b00, partial, error, overflow, frame_valid, 1'b0, enable};
                default: rd_data = {7'b0000000, rxState};
            endcase
        end else if (busAddr[12:0] <= BUF_LAST) begin
            rd_data = buf_mem[busAddr[BUF_AW-1:0]];
        end
    end

    // Bus side: enable bit write and registered read data
    always_ff @(posedge clk7mhz or negedge resetn) begin
        if (!resetn) begin
            enable     <= 1'b0;
            busDataOut <= '0;
        end else begin
            if (ctrl_wr) enable <= busDataIn[0];
            if (busRead) busDataOut <= rd_data;
        end
    end

endmodule

// File: tb/tb_anton_neopixel_rx.sv
// Directed plus randomized bench for anton_neopixel_rx with a bit-queue
// reference model of the expected buffer, count and status flags.

module tb_anton_neopixel_rx;

    localparam int BEND = 3;
    localparam logic [13:0] R_CLO  = 14'h2000;
    localparam logic [13:0] R_CHI  = 14'h2001;
    localparam logic [13:0] R_CTRL = 14'h2002;
    localparam logic [13:0] R_RX   = 14'h2003;

    logic        clk7mhz;
    logic        resetn;
    logic        neoDataIn;
    logic        rxState;
    logic        frameDone;
    logic [13:0] busAddr;
    logic [7:0]  busDataIn;
    logic        busWrite;
    logic        busRead;
    logic [7:0]  busDataOut;

    int vectors;
    int miscompares;
    int fd_cnt;
    int fd0;
    bit tx_bits[$];

    anton_neopixel_rx #(.BUFFER_END(BEND), .RESET_DELAY(385)) dut (
        .clk7mhz   (clk7mhz),
        .resetn    (resetn),
        .neoDataIn (neoDataIn),
        .rxState   (rxState),
        .frameDone (frameDone),
        .busAddr   (busAddr),
        .busDataIn (busDataIn),
        .busWrite  (busWrite),
        .busRead   (busRead),
        .busDataOut(busDataOut)
    );

    initial clk7mhz = 1'b0;
    always #5 clk7mhz = ~clk7mhz;

    always @(negedge clk7mhz) if (frameDone === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        neoDataIn = lvl;
        repeat (n) @(negedge clk7mhz);
    endtask

    task automatic send_pulse(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic bus_write(input logic [13:0] a, input logic [7:0] d);
        busAddr = a; busDataIn = d; busWrite = 1'b1;
        @(negedge clk7mhz);
        busWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [13:0] a, output logic [7:0] d);
        busAddr = a; busRead = 1'b1;
        @(negedge clk7mhz);
        busRead = 1'b0;
        d = busDataOut;
    endtask

    task automatic check_reg(input string tag, input logic [13:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(tag, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
    endtask

    // Nominal: '0' = 2 high / 7 low, '1' = 5 high / 4 low; otherwise random legal widths
    task automatic send_tx(input bit nominal);
        foreach (tx_bits[i]) begin
            if (nominal) send_pulse(tx_bits[i] ? 5 : 2, tx_bits[i] ? 4 : 7);
            else if (tx_bits[i]) send_pulse(int'($urandom_range(7, 4)), int'($urandom_range(20, 2)));
            else send_pulse(int'($urandom_range(3, 1)), int'($urandom_range(20, 2)));
        end
    endtask

    // Reference: bytes are consecutive groups of 8 queued bits, MSB first
    task automatic check_frame(input string tag, input bit err);
        int nbits;
        int nb;
        int ncap;
        logic [7:0] ctrl_exp;
        logic [7:0] b;
        nbits = tx_bits.size();
        nb    = nbits / 8;
        ncap  = (nb > BEND + 1) ? BEND + 1 : nb;
        ctrl_exp = 8'h05;
        if (nb > BEND + 1)    ctrl_exp = ctrl_exp | 8'h08;
        if (err)              ctrl_exp = ctrl_exp | 8'h10;
        if (nbits % 8 != 0)   ctrl_exp = ctrl_exp | 8'h20;
        check({tag, ".frameDone"}, 16'(fd_cnt - fd0), 16'd1);
        check_reg({tag, ".cnt_lo"}, R_CLO, 8'(ncap));
        check_reg({tag, ".cnt_hi"}, R_CHI, 8'(ncap >> 8));
        check_reg({tag, ".ctrl"}, R_CTRL, ctrl_exp);
        check_reg({tag, ".rx"}, R_RX, 8'h00);
        for (int k = 0; k < ncap; k++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], tx_bits[8 * k + j]};
            check_reg($sformatf("%s.buf%0d", tag, k), 14'(k), b);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; fd_cnt = 0;
        resetn = 1'b0; neoDataIn = 1'b0; busAddr = '0; busDataIn = '0;
        busWrite = 1'b0; busRead = 1'b0;
        repeat (5) @(negedge clk7mhz);
        check("rst.rxState", {15'd0, rxState}, 16'd0);
        check("rst.frameDone", {15'd0, frameDone}, 16'd0);
        check("rst.busDataOut", {8'd0, busDataOut}, 16'd0);
        resetn = 1'b1;
        @(negedge clk7mhz);
        check_reg("rst.cnt_lo", R_CLO, 8'h00);
        check_reg("rst.cnt_hi", R_CHI, 8'h00);
        check_reg("rst.ctrl", R_CTRL, 8'h00);
        check_reg("rst.rx", R_RX, 8'h00);

        // Basic three-byte frame with nominal timing
        bus_write(R_CTRL, 8'h01);
        hold(1'b0, 400);
        tx_bits.delete();
        push_byte(8'hA5); push_byte(8'h0F); push_byte(8'hFF);
        fd0 = fd_cnt;
        for (int i = 0; i < 8; i++) send_pulse(tx_bits[i] ? 5 : 2, tx_bits[i] ? 4 : 7);
        check("t1.rxState_mid", {15'd0, rxState}, 16'd1);
        check_reg("t1.rx_mid", R_RX, 8'h01);
        for (int i = 8; i < 24; i++) send_pulse(tx_bits[i] ? 5 : 2, tx_bits[i] ? 4 : 7);
        hold(1'b0, 400);
        check_frame("t1", 1'b0);

        // Enable while pulses are already running: nothing decodes until a gap
        bus_write(R_CTRL, 8'h02);
        tx_bits.delete();
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        fd0 = fd_cnt;
        fork
            send_tx(1'b1);
            begin
                repeat (100) @(negedge clk7mhz);
                bus_write(R_CTRL, 8'h01);
            end
        join
        hold(1'b0, 200);
        check("t2.no_frameDone", 16'(fd_cnt - fd0), 16'd0);
        check_reg("t2.cnt_lo", R_CLO, 8'h00);
        check_reg("t2.ctrl", R_CTRL, 8'h01);
        hold(1'b0, 200);
        tx_bits.delete();
        push_byte(8'h3C); push_byte(8'h81);
        fd0 = fd_cnt;
        send_tx(1'b0);
        hold(1'b0, 400);
        check_frame("t2", 1'b0);

        // Overflow: six bytes into a four-byte buffer
        bus_write(R_CTRL, 8'h03);
        hold(1'b0, 400);
        tx_bits.delete();
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        fd0 = fd_cnt;
        send_tx(1'b0);
        hold(1'b0, 400);
        check_frame("t3", 1'b0);

        // Over-long high pulse aborts the frame; next frame decodes after a gap
        bus_write(R_CTRL, 8'h03);
        hold(1'b0, 400);
        tx_bits.delete();
        push_byte(8'($urandom));
        send_tx(1'b0);
        hold(1'b1, 8);
        hold(1'b0, 20);
        check("t4.rxState", {15'd0, rxState}, 16'd0);
        check_reg("t4.ctrl_err", R_CTRL, 8'h11);
        check_reg("t4.cnt_lo", R_CLO, 8'h00);
        begin
            logic [7:0] b0;
            b0 = 8'h00;
            for (int j = 0; j < 8; j++) b0 = {b0[6:0], tx_bits[j]};
            check_reg("t4.buf0_kept", 14'h0000, b0);
        end
        hold(1'b0, 400);
        tx_bits.delete();
        push_byte(8'($urandom)); push_byte(8'($urandom));
        fd0 = fd_cnt;
        send_tx(1'b0);
        hold(1'b0, 400);
        check_frame("t4", 1'b1);

        // Twelve bits: one byte plus leftovers, then clear
        bus_write(R_CTRL, 8'h03);
        hold(1'b0, 400);
        tx_bits.delete();
        for (int i = 0; i < 12; i++) tx_bits.push_back(1'($urandom));
        fd0 = fd_cnt;
        send_tx(1'b0);
        hold(1'b0, 400);
        check_frame("t5", 1'b0);
        bus_write(R_CTRL, 8'h03);
        check_reg("t5.clr_cnt_lo", R_CLO, 8'h00);
        check_reg("t5.clr_cnt_hi", R_CHI, 8'h00);
        check_reg("t5.clr_ctrl", R_CTRL, 8'h01);

        // Reset in the middle of byte 2
        hold(1'b0, 400);
        tx_bits.delete();
        push_byte(8'hC3); push_byte(8'h5A); push_byte(8'h99);
        fork
            send_tx(1'b1);
            begin
                repeat (100) @(negedge clk7mhz);
                check("t6.rx_before", {15'd0, rxState}, 16'd1);
                resetn = 1'b0;
                @(negedge clk7mhz);
                check("t6.rxState", {15'd0, rxState}, 16'd0);
                check("t6.busDataOut", {8'd0, busDataOut}, 16'd0);
                check("t6.frameDone", {15'd0, frameDone}, 16'd0);
                repeat (3) @(negedge clk7mhz);
                resetn = 1'b1;
            end
        join
        check_reg("t6.ctrl", R_CTRL, 8'h00);
        check_reg("t6.cnt_lo", R_CLO, 8'h00);
        bus_write(R_CTRL, 8'h01);
        hold(1'b0, 400);
        tx_bits.delete();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        fd0 = fd_cnt;
        send_tx(1'b0);
        hold(1'b0, 400);
        check_frame("t6", 1'b0);

        // Random frames: random length, leftover bits and pulse widths
        for (int f = 0; f < 8; f++) begin
            int nbytes;
            int extra;
            bus_write(R_CTRL, 8'h03);
            hold(1'b0, 400);
            tx_bits.delete();
            nbytes = int'($urandom_range(6, 0));
            extra  = int'($urandom_range(7, 0));
            if (nbytes == 0 && extra == 0) extra = 1;
            for (int i = 0; i < nbytes * 8 + extra; i++) tx_bits.push_back(1'($urandom));
            fd0 = fd_cnt;
            send_tx(1'b0);
            hold(1'b0, 400);
            check_frame($sformatf("rnd%0d", f), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
